alu_share_arbiter: RTL

- Shares the single combinational RV32I ALU between two requesters: req0 = integer execute pipe, req1 = branch/address unit.
- Arbitrates round-robin, drives the ALU operand and op inputs, and captures the result plus flags in a one-entry output register.
- Returns the captured response on a valid/ready channel, tagged with requester ID and tag.
- Sits between issue logic and the ALU instance inside the execute cluster.

---
 rtl/alu_share_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational RV32I ALU between two requesters:
//   req0 is the integer execute pipe and req1 is the branch/address unit.
//   A round-robin arbiter picks one request per cycle. The winner's operands
//   and op code drive the ALU. The ALU result and flags are captured in a
//   one-entry response register. That register is returned on a
//   valid/ready channel, tagged with the requester id and its tag.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for requester N (0/1)
//   reqN_op / reqN_a / reqN_b   ALU op code and operands
//   reqN_tag                    opaque tag echoed with the response
//   alu_srca/alu_srcb/alu_op    drive the shared ALU (NOP and zeros when idle)
//   alu_result/zero/lt/ltu      ALU outputs, captured on a transfer
//   rsp_valid / rsp_ready       response handshake
//   rsp_id / rsp_tag            requester id and echoed tag
//   rsp_result/zero/lt/ltu      captured ALU result and flags
//
// Optional feature (macro ALU_ARB_STATS_EN)
//   When the macro is defined, the block adds three saturating 32-bit
//   counters: stat_grant0, stat_grant1 and stat_stall.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      alu_srca,
  output logic [31:0]      alu_srcb,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_lt,
  output logic             rsp_ltu
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]      stat_grant0,
  output logic [31:0]      stat_grant1,
  output logic [31:0]      stat_stall
`endif
);

  localparam logic [3:0] OP_NOP = 4'b1010;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       last_grant_r;
  logic       can_issue_s;
  logic       grant_valid_s;
  logic       grant_s;
  logic       xfer_s;

`ifdef ALU_ARB_STATS_EN
  // Increment a counter by one, holding at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction
`endif

  assign rsp_valid = (state_r == FULL);

  // Arbitration: pick a winner only when the response slot can take a result.
  // During reset nothing can issue, so both readies stay low.
  always_comb begin
    can_issue_s   = 1'b0;
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    if (rst) begin
      can_issue_s = 1'b0;
    end else begin
      can_issue_s = !rsp_valid || rsp_ready;
    end
    if (req0_valid && req1_valid) begin
      // On a conflict, the requester that did not win last time wins now.
      grant_valid_s = can_issue_s;
      grant_s       = ~last_grant_r;
    end else if (req0_valid) begin
      grant_valid_s = can_issue_s;
      grant_s       = 1'b0;
    end else if (req1_valid) begin
      grant_valid_s = can_issue_s;
      grant_s       = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
    end
  end

  // A grant implies the winner is valid, so a grant is also a transfer.
  assign xfer_s     = grant_valid_s;
  assign req0_ready = grant_valid_s && (grant_s == 1'b0);
  assign req1_ready = grant_valid_s && (grant_s == 1'b1);

  // Steer the winning payload onto the ALU. When no request wins, send NOP with zero operands.
  always_comb begin
    alu_srca = 32'd0;
    alu_srcb = 32'd0;
    alu_op   = OP_NOP;
    if (grant_valid_s && grant_s) begin
      alu_srca = req1_a;
      alu_srcb = req1_b;
      alu_op   = req1_op;
    end else if (grant_valid_s) begin
      alu_srca = req0_a;
      alu_srcb = req0_b;
      alu_op   = req0_op;
    end else begin
      alu_srca = 32'd0;
      alu_srcb = 32'd0;
      alu_op   = OP_NOP;
    end
  end

  // Response-slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a transfer always fills the slot, and a drain without a refill empties it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = FULL;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      FULL: begin
        if (xfer_s) begin
          state_nxt_s = FULL;
        end else if (rsp_ready) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = FULL;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Capture the ALU response and remember the winner on every transfer.
  // last_grant resets to 1 so that req0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id       <= 1'b0;
      rsp_tag      <= '0;
      rsp_result   <= 32'd0;
      rsp_zero     <= 1'b0;
      rsp_lt       <= 1'b0;
      rsp_ltu      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (xfer_s) begin
      rsp_id       <= grant_s;
      rsp_tag      <= grant_s ? req1_tag : req0_tag;
      rsp_result   <= alu_result;
      rsp_zero     <= alu_zero;
      rsp_lt       <= alu_lt;
      rsp_ltu      <= alu_ltu;
      last_grant_r <= grant_s;
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Grant and stall statistics. A cycle counts as one stall even if both requesters stall in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0 <= 32'd0;
      stat_grant1 <= 32'd0;
      stat_stall  <= 32'd0;
    end else begin
      if (req0_valid && req0_ready) begin
        stat_grant0 <= sat_inc(stat_grant0);
      end
      if (req1_valid && req1_ready) begin
        stat_grant1 <= sat_inc(stat_grant1);
      end
      if ((req0_valid && !req0_ready) || (req1_valid && !req1_ready)) begin
        stat_stall <= sat_inc(stat_stall);
      end
    end
  end
`endif

endmodule
